stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor to the 4:1 combinational multiplexer.
- Selects one of CHANNELS input streams, each WIDTH bits wide, and forwards it through one registered output stage with valid/ready handshakes.
- Two selection modes:
  - fixed: external select, the direct generalisation of the 4:1 select input.
  - round-robin: fair arbitration among the valid channels.
- Sits between several producer blocks and one shared consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready, combinational.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the source channel of out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (async, rst=1), held while rst=1:
  - out_valid=0, out_data=0, out_chan=0.
  - round-robin pointer ptr=0.
  - in_ready=0.
- Output register states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = !out_valid | out_ready.
- Grant, combinational; at most one bit of grant set:
  - mode=0: grant channel sel iff sel<CHANNELS and in_valid[sel]=1; otherwise no grant.
  - mode=1: grant the first i with in_valid[i]=1, searching ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1 (wrap-around); otherwise no grant.
- in_ready[i] = grant[i] & load_en.
  - No input is ever readied unless it is granted.
  - in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- Transfer on input i when in_valid[i] & in_ready[i] at a rising edge:
  - next cycle: out_data = channel i data, out_chan = i, out_valid=1.
  - latency: exactly 1 cycle from input transfer to out_valid.
- Drain without refill:
  - out_valid & out_ready and no grant → out_valid=0 next cycle.
  - out_data and out_chan hold their last values.
- Simultaneous drain and refill:
  - out_valid & out_ready together with a grant → new word loaded, out_valid stays 1.
  - full throughput: one word per cycle, no bubble.
- Stall: out_valid & !out_ready → out_data and out_chan hold stable; all in_ready=0.
- Pointer:
  - updates only on a transfer in mode=1: ptr = (granted index + 1) mod CHANNELS.
  - unchanged in mode=0 and on cycles without transfer.
  - wrap from CHANNELS-1 goes to 0, never to an unused index.
- Mode or sel change:
  - takes effect on the grant in the same cycle.
  - never disturbs a word already held in the output register.
- No invalid input is ever captured; no input word is dropped or duplicated.
- Reset asserted mid-operation:
  - held word is discarded immediately (out_valid=0 asynchronously).
  - ptr returns to 0.
  - first transfer after deassertion is evaluated from ptr=0.

Test Plan:
- Reset: rst=1 with out_valid previously 1 → out_valid=0 and in_ready=4'b0000 before the next clk edge; out_data=8'h00.
- Fixed mode, CHANNELS=4: mode=0, sel=2, in_valid=4'b1111, channel data A0/B1/C2/D3 (channel 0..3), out_ready=1 → in_ready=4'b0100; out_data=8'hC2 and out_chan=2 one cycle later; sel=1 with in_valid[1]=0 → in_ready=0, out_valid drops.
- Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1 → out_chan sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Round-robin skip and wrap: ptr=3, in_valid=4'b0101 → channel 0 granted (wrap), ptr becomes 1; next grant is channel 2.
- Backpressure: out_ready=0 for 3 cycles with word 8'h5A held → out_data=8'h5A stable, in_ready=0, no input lost; out_ready=1 → 8'h5A consumed and the next word loads in the same cycle.
- Reset mid-stream: assert rst during a round-robin burst at ptr=2 → out_valid=0 at once; after release with all channels valid, first out_chan=0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: CHANNELS:1 stream multiplexer with fixed or round-robin select and one registered output stage
//   mode/sel           : 0 = fixed channel sel, 1 = round-robin among valid channels
//   in_data/in_valid   : packed producer streams, channel i at [i*WIDTH +: WIDTH]
//   in_ready           : combinational, set only for the granted channel when the output can load
//   out_data/out_chan  : registered word and its source channel, qualified by out_valid/out_ready
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [WIDTH-1:0]    data_q, data_d, gnt_data;
  logic [SEL_W-1:0]    chan_q, chan_d, ptr_q, ptr_d, gnt_idx;
  logic                valid_q, valid_d, any, load_en, xfer;
  logic [CHANNELS-1:0] grant;
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_data = '0;
    any      = 1'b0;
    // rotate the search start to ptr_q so the first hit is the next channel in turn
    for (int k = 0; k < CHANNELS; k++) begin
      int j;
      j = mode ? (int'(ptr_q) + k) % CHANNELS : k;
      if (!any && in_valid[j] && (mode || int'(sel) == j)) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        gnt_idx  = SEL_W'(j);
        gnt_data = in_data[j*WIDTH +: WIDTH];
      end
    end
  end
  assign load_en   = !valid_q || out_ready;
  assign xfer      = any && load_en;
  assign in_ready  = rst ? '0 : (grant & {CHANNELS{load_en}});
  assign valid_d   = xfer || (valid_q && !out_ready);
  assign data_d    = xfer ? gnt_data : data_q;
  assign chan_d    = xfer ? gnt_idx : chan_q;
  assign ptr_d     = (xfer && mode) ? SEL_W'((int'(gnt_idx) + 1) % CHANNELS) : ptr_q;
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: self-checking bench for stream_mux_rr against a queue-based reference model
module tb_stream_mux_rr;
  localparam int W = 8;
  localparam int C = 4;
  localparam int S = 2;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           mode = 1'b0;
  logic [S-1:0]   sel = '0;
  logic [W-1:0]   dat [C];
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid = '0;
  logic [C-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_chan;
  logic           out_valid;
  logic           out_ready = 1'b0;
  int             n_cmp = 0;
  int             n_bad = 0;
  int             m_ptr = 0;
  logic [S+W-1:0] m_q [$];

  stream_mux_rr #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < C; i++) in_data[i*W +: W] = dat[i];

  // smallest valid index at or above the pointer, else smallest valid index overall
  function automatic int exp_grant();
    int best = -1;
    int low = -1;
    if (!mode) return (int'(sel) < C && in_valid[sel]) ? int'(sel) : -1;
    for (int i = 0; i < C; i++)
      if (in_valid[i]) begin
        if (low < 0) low = i;
        if (best < 0 && i >= m_ptr) best = i;
      end
    return best >= 0 ? best : low;
  endfunction

  function automatic logic [C-1:0] exp_ready();
    int g = exp_grant();
    bit load = (m_q.size() == 0) || out_ready;
    return (!rst && g >= 0 && load) ? C'(1 << g) : '0;
  endfunction

  task automatic tick();
    int g = exp_grant();
    bit load = (m_q.size() == 0) || out_ready;
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (g >= 0 && load) begin
      m_q.push_back({S'(g), dat[g]});
      if (mode) m_ptr = (g + 1) % C;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_q.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 1'b0; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", out_data); end
    n_cmp++; if (out_chan !== 2'd0) begin n_bad++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", in_ready); end
    in_valid = '0;
    do_reset();
  endtask

  task automatic test_fixed();
    dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hC2 || out_chan !== 2'd2) begin
      n_bad++; $display("FAIL fixed_word got v%b %h ch%0d want v1 c2 ch2", out_valid, out_data, out_chan); end
    sel = 2'd1; in_valid = 4'b1101;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL fixed_nogrant got %b want 0000", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'hC2 || out_chan !== 2'd2) begin
      n_bad++; $display("FAIL fixed_drain got v%b %h ch%0d want v0 c2 ch2", out_valid, out_data, out_chan); end
  endtask

  task automatic test_rr_fair();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_chan !== S'(i % C)) begin
        n_bad++; $display("FAIL rr_seq[%0d] got v%b ch%0d want v1 ch%0d", i, out_valid, out_chan, i % C); end
    end
  endtask

  task automatic test_rr_wrap();
    in_valid = 4'b0101;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_wrap_ready got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_chan !== 2'd0) begin n_bad++; $display("FAIL rr_wrap_chan got %0d want 0", out_chan); end
    n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL rr_skip_ready got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_chan !== 2'd2) begin n_bad++; $display("FAIL rr_skip_chan got %0d want 2", out_chan); end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; dat[1] = 8'h5A; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; dat[1] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v%b %h want v1 5a", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release_ready got %b want 0010", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h77 || out_chan !== 2'd1) begin
      n_bad++; $display("FAIL bp_refill got v%b %h ch%0d want v1 77 ch1", out_valid, out_data, out_chan); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    m_q.delete();
    m_ptr = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_reset_ready got %b want 0000", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL post_reset_ready got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
      n_bad++; $display("FAIL post_reset_chan got v%b ch%0d want v1 ch0", out_valid, out_chan); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 3) != 0;
      sel = S'($urandom);
      in_valid = C'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < C; i++) dat[i] = W'($urandom);
      #1;
      n_cmp++; if (in_ready !== exp_ready()) begin
        n_bad++; $display("FAIL rand_ready[%0d] got %b want %b", n, in_ready, exp_ready()); end
      tick();
      n_cmp++; if (out_valid !== (m_q.size() > 0)) begin
        n_bad++; $display("FAIL rand_valid[%0d] got %b want %b", n, out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_cmp++; if ({out_chan, out_data} !== m_q[0]) begin
          n_bad++; $display("FAIL rand_word[%0d] got ch%0d %h want ch%0d %h", n, out_chan, out_data, m_q[0][S+W-1:W], m_q[0][W-1:0]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < C; i++) dat[i] = '0;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
